// File: rtl/rr_arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   NUM_REQ / ID_W : requester count and grant index width
//   rr_state_t     : arbiter FSM states
//   rr_pick_t      : result of a round-robin search (found flag + index)
//   next_rr()      : rotating-priority search starting at ptr, optionally
//                    skipping one requester (the current grantee on preempt)
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } rr_state_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } rr_pick_t;

    // Walk ptr+3 down to ptr+0 so the lowest offset from ptr is written last
    // and therefore wins. Index arithmetic wraps naturally in ID_W bits.
    function automatic rr_pick_t next_rr(
        input logic [NUM_REQ-1:0] req,
        input logic [ID_W-1:0]    ptr,
        input logic               exclude_en,
        input logic [ID_W-1:0]    exclude_id
    );
        rr_pick_t        r;
        logic [ID_W-1:0] c;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            c = ptr + ID_W'(i);
            if (req[c] && !(exclude_en && (c == exclude_id))) begin
                r.found = 1'b1;
                r.idx   = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder2to4.sv
// 2-to-4 one-hot decoder with enable.
//   a : 2-bit select
//   e : enable; when low all outputs are zero
//   y : one-hot output, y[a] = e
module decoder2to4 (
    input  logic [1:0] a,
    input  logic       e,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (e) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant-hold and forced rotation.
//   clk    : clock, all state on rising edge
//   rst    : synchronous active-high reset
//   req    : request vector, bit i = requester i wants the resource
//   gnt    : one-hot grant, decoded from registered gnt_id/gnt_en
//   gnt_id : registered index of the current grantee
//   gnt_en : registered grant-valid
//   busy   : same as gnt_en
// A grantee keeps the resource while its request stays high. If it has held
// for MAX_HOLD cycles and someone else is waiting, it is rotated out as if it
// had released. MAX_HOLD = 0 disables rotation.
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_en,
    output logic               busy
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    rr_state_t       state_q,    state_d;
    logic [ID_W-1:0] gnt_id_q,   gnt_id_d;
    logic            gnt_en_q,   gnt_en_d;
    logic [ID_W-1:0] ptr_q,      ptr_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    rr_pick_t          pick;
    logic [NUM_REQ-1:0] own_mask;
    logic              release_c;
    logic              preempt_c;
    logic              others_c;
    logic [ID_W-1:0]   ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_id_q   <= '0;
            gnt_en_q   <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            gnt_en_q   <= gnt_en_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        gnt_en_d   = gnt_en_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        own_mask  = NUM_REQ'(1) << gnt_id_q;
        others_c  = |(req & ~own_mask);
        release_c = ~req[gnt_id_q];
        preempt_c = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)
                    && req[gnt_id_q] && others_c;
        ptr_next  = gnt_id_q + ID_W'(1);
        pick      = '0;

        unique case (state_q)
            ST_IDLE: begin
                pick = next_rr(req, ptr_q, 1'b0, '0);
                if (pick.found) begin
                    state_d    = ST_GRANT;
                    gnt_id_d   = pick.idx;
                    gnt_en_d   = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (release_c || preempt_c) begin
                    // Release and preempt share this path; excluding the
                    // current grantee is a no-op when it has released.
                    ptr_d      = ptr_next;
                    hold_cnt_d = '0;
                    pick       = next_rr(req, ptr_next, 1'b1, gnt_id_q);
                    if (pick.found) begin
                        gnt_id_d = pick.idx;
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_en_d = 1'b0;
                    end
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_en_d = 1'b0;
            end
        endcase
    end

    decoder2to4 u_dec (
        .a (gnt_id_q),
        .e (gnt_en_q),
        .y (gnt)
    );

    assign gnt_id = gnt_id_q;
    assign gnt_en = gnt_en_q;
    assign busy   = gnt_en_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a vector table for reset, latency,
// fairness and wrap, then hand-written multi-cycle rotation/reset cases.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst, rst0;
    logic [3:0] req, req0;
    logic [3:0] gnt, gnt0;
    logic [1:0] gnt_id, gnt_id0;
    logic       gnt_en, gnt_en0, busy, busy0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_en(gnt_en), .busy(busy)
    );

    rr_arbiter4 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst0), .req(req0),
        .gnt(gnt0), .gnt_id(gnt_id0), .gnt_en(gnt_en0), .busy(busy0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vt[22];
    logic [3:0] exp_g;

    initial begin
        rst  = 1'b1; req  = 4'b0000;
        rst0 = 1'b1; req0 = 4'b0000;

        // inputs applied before the edge, outputs expected after it
        vt[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};  // reset with req high
        vt[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        vt[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // idle
        vt[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};  // 1-cycle latency
        vt[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // release, ptr=3
        vt[8]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1};  // search from 3
        vt[9]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};  // wrap 3->0, no bubble
        vt[10] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[11] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};  // reset for fairness
        vt[12] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vt[13] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vt[14] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
        vt[15] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};
        vt[16] = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
        vt[17] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
        vt[18] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
        vt[19] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
        vt[20] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
        vt[21] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};

        for (int i = 0; i < 22; i++) begin
            rst = vt[i].rst;
            req = vt[i].req;
            step();
            chk($sformatf("vec%0d gnt", i), gnt, vt[i].gnt);
            chk($sformatf("vec%0d busy", i), {3'b000, busy}, {3'b000, vt[i].busy});
            chk($sformatf("vec%0d gnt_en", i), {3'b000, gnt_en}, {3'b000, vt[i].busy});
            if (vt[i].busy || vt[i].rst)
                chk($sformatf("vec%0d gnt_id", i), {2'b00, gnt_id}, {2'b00, vt[i].id});
        end

        // forced rotation (MAX_HOLD=8) alongside no rotation (MAX_HOLD=0)
        rst = 1'b1; rst0 = 1'b1; req = 4'b0000; req0 = 4'b0000;
        step();
        rst = 1'b0; rst0 = 1'b0; req = 4'b0011; req0 = 4'b0011;
        for (int k = 0; k < 24; k++) begin
            step();
            exp_g = (k >= 8 && k < 16) ? 4'b0010 : 4'b0001;
            chk($sformatf("rot cyc%0d", k), gnt, exp_g);
            chk($sformatf("norot cyc%0d", k), gnt0, 4'b0001);
        end

        // lone requester is never preempted
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("lone cyc%0d", k), gnt, 4'b0001);
        end

        // reset mid-grant
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b0100;
        step();
        chk("midrst pre", gnt, 4'b0100);
        rst = 1'b1;
        step();
        chk("midrst gnt", gnt, 4'b0000);
        chk("midrst busy", {3'b000, busy}, 4'b0000);
        rst = 1'b0; req = 4'b0000;
        step();
        chk("midrst idle", gnt, 4'b0000);

        // release on the same cycle hold limit is reached
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b0010;
        step();
        chk("relpre hold0", gnt, 4'b0010);
        req = 4'b1010;
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("relpre hold%0d", k), gnt, 4'b0010);
        end
        req = 4'b1000;
        step();
        chk("relpre gnt", gnt, 4'b1000);
        chk("relpre id", {2'b00, gnt_id}, 4'd3);
        req = 4'b0000;
        step();
        chk("relpre idle", gnt, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
